score_sequencer: RTL
====================

// Module: score_sequencer
// PURPOSE
//  Sequences the two player score counters (4-bit, per-op modes: +1, +2, -1, clear) from asynchronous player events.
//  One registered command goes to one counter per issue slot; left and right requests share the slot round-robin.
//  Also runs the game FSM: start, play, win detect, stop. Sits between the input-sync logic and the score counters.
// PARAMETERS
//  WIN_SCORE  4'd10  score (1..15) at which a player wins; the counter is never driven past this value
// PORTS
//  Clock     in   1  clock, all state on posedge
//  Reset     in   1  reset, synchronous, active-high
//  start     in   1  pulse; starts a new game from IDLE or OVER
//  L_pt      in   1  left +1 request (1-cycle pulse); R_pt is the right-side equivalent
//  L_bonus   in   1  left +2 request; R_bonus is the right-side equivalent
//  L_pen     in   1  left -1 request; R_pen is the right-side equivalent
//  scoreL    in   4  current left counter value; scoreR is the right-side equivalent
//  cnt_en    out  1  registered; one-cycle command strobe to the counter selected by cnt_sel
//  cnt_sel   out  1  0=left counter, 1=right counter
//  cnt_op    out  2  00 none, 01 +1, 10 +2, 11 -1
//  cnt_clr   out  1  one-cycle clear to both counters
//  stop      out  1  high when not in PLAY/ISSUE/CHECK
//  winner    out  2  00 none, 01 left, 10 right
//  overflow  out  1  sticky; a request was dropped because that player's pending slot was full
// BEHAVIOUR
//  Reset: state IDLE; stop=1; cnt_en=0, cnt_sel=0, cnt_op=00, cnt_clr=0, winner=00, overflow=0.
//    Reset also clears both pending slots and sets rr pointer to left. Reset wins over every other input.
//  States: IDLE, CLEAR, PLAY, ISSUE, CHECK, OVER.
//  IDLE, start=1 -> CLEAR. OVER, start=1 -> CLEAR.
//  CLEAR: cnt_clr=1 for exactly one cycle; clears pending slots, winner and overflow -> PLAY.
//  Pending slots: one per player, each holds a 2-bit op.
//    Sampled every cycle in CLEAR exit, PLAY, ISSUE and CHECK.
//    Same-cycle multi-request from one player: bonus > pt > pen; lower-priority requests are discarded silently.
//    New request while that player's slot is full: request dropped; overflow <= 1.
//  PLAY: if any slot is full, grant one slot; both full -> grant rr pointer, then flip rr to the other player -> ISSUE.
//  ISSUE: registered outputs cnt_en=1, cnt_sel and cnt_op from the granted slot; slot cleared -> CHECK.
//  CHECK: one wait cycle so the counter update is visible on scoreX.
//    scoreL>=WIN_SCORE -> winner=01, OVER. scoreR>=WIN_SCORE -> winner=10, OVER. Otherwise -> PLAY.
//    Both at/above WIN_SCORE cannot occur: one issue per CHECK.
//  Latency: request high in cycle c -> cnt_en high in cycle c+2 at the earliest; issue rate is at most 1 per 3 cycles.
//  Arithmetic guards, applied at grant using the current score; widths stay 4-bit with no wrap:
//    -1 with score==0: op dropped, slot cleared, no cnt_en, state stays PLAY.
//    +2 with score==WIN_SCORE-1: issued as +1.
//    Any increment with score>=WIN_SCORE: dropped.
//  OVER: stop=1, winner held; all requests ignored and slots held empty; cnt_en=0.
//  IDLE: requests ignored.
//  start in PLAY/ISSUE/CHECK: ignored.
//  Outputs are registered; no combinational input-to-output paths.
// CONFIGURATION
//  SCORE_BONUS_EN defined: bonus requests map to +2, subject to the clamp rule above.
//  SCORE_BONUS_EN undefined: L_bonus/R_bonus are treated as L_pt/R_pt; cnt_op never equals 10.
// TESTING
//  Reset mid-ISSUE -> next cycle IDLE, cnt_en=0, stop=1, winner=00, overflow=0.
//  start; L_pt and R_pt in the same cycle, both scores 0
//    -> left issued first (cnt_sel=0, op 01), then right 3 cycles later (cnt_sel=1, op 01).
//  L_pen with scoreL=0 -> no cnt_en; state returns to PLAY.
//  L_pen with scoreL=3 -> cnt_op=11.
//  SCORE_BONUS_EN, WIN_SCORE=10, scoreL=9, L_bonus -> cnt_op=01; CHECK sees scoreL=10 -> winner=01, stop=1.
//  L_pt twice within 2 cycles while the slot is pending -> second request dropped, overflow=1; start -> overflow=0.
//  In OVER, R_pt pulses -> no cnt_en. start -> cnt_clr one cycle, then PLAY with stop=0, winner=00.

Source files
------------

// File: rtl/score_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : score_sequencer
// Summary  : Game FSM and round-robin command issue for two 4-bit score
//            counters. Define SCORE_BONUS_EN to map bonus requests to +2.
// Revision : 1.0 - initial release
// ============================================================================
module score_sequencer #(
  parameter logic [3:0] WIN_SCORE = 4'd10
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       start,
  input  logic       L_pt,
  input  logic       R_pt,
  input  logic       L_bonus,
  input  logic       R_bonus,
  input  logic       L_pen,
  input  logic       R_pen,
  input  logic [3:0] scoreL,
  input  logic [3:0] scoreR,
  output logic       cnt_en,
  output logic       cnt_sel,
  output logic [1:0] cnt_op,
  output logic       cnt_clr,
  output logic       stop,
  output logic [1:0] winner,
  output logic       overflow
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_CHECK = 3'd4;
  localparam logic [2:0] S_OVER  = 3'd5;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_INC1 = 2'b01;
  localparam logic [1:0] OP_INC2 = 2'b10;
  localparam logic [1:0] OP_DEC1 = 2'b11;

  // Highest-priority request wins: bonus > pt > pen.
  function automatic logic [1:0] encode_req(input logic pt, input logic bonus,
                                            input logic pen);
    logic [1:0] op;
    op = OP_NONE;
    if (bonus) begin
`ifdef SCORE_BONUS_EN
      op = OP_INC2;
`else
      op = OP_INC1;
`endif
    end else if (pt) begin
      op = OP_INC1;
    end else if (pen) begin
      op = OP_DEC1;
    end
    return op;
  endfunction

  // Keeps the counter inside 0..WIN_SCORE without wrapping.
  function automatic logic [1:0] guard_op(input logic [1:0] op, input logic [3:0] score);
    logic [1:0] res;
    res = OP_NONE;
    case (op)
      OP_INC1: res = (score >= WIN_SCORE) ? OP_NONE : OP_INC1;
      OP_INC2: begin
        if (score >= WIN_SCORE)               res = OP_NONE;
        else if (score == WIN_SCORE - 4'd1)   res = OP_INC1;
        else                                  res = OP_INC2;
      end
      OP_DEC1: res = (score == 4'd0) ? OP_NONE : OP_DEC1;
      default: res = OP_NONE;
    endcase
    return res;
  endfunction

  logic [2:0] state_q, state_d;
  logic [1:0] slot_l_q, slot_l_d, slot_r_q, slot_r_d;
  logic       rr_q, rr_d;
  logic       cnt_en_q, cnt_en_d, cnt_sel_q, cnt_sel_d, cnt_clr_q, cnt_clr_d;
  logic [1:0] cnt_op_q, cnt_op_d, winner_q, winner_d;
  logic       stop_q, stop_d, overflow_q, overflow_d;

  logic       l_full, r_full, grant_valid, grant_sel;
  logic [1:0] grant_op, req_l, req_r;

  always_comb begin
    l_full      = (slot_l_q != OP_NONE);
    r_full      = (slot_r_q != OP_NONE);
    grant_valid = (state_q == S_PLAY) && (l_full || r_full);
    grant_sel   = (l_full && r_full) ? rr_q : r_full;
    grant_op    = grant_sel ? guard_op(slot_r_q, scoreR) : guard_op(slot_l_q, scoreL);
    req_l       = encode_req(L_pt, L_bonus, L_pen);
    req_r       = encode_req(R_pt, R_bonus, R_pen);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      slot_l_q   <= OP_NONE;
      slot_r_q   <= OP_NONE;
      rr_q       <= 1'b0;
      cnt_en_q   <= 1'b0;
      cnt_sel_q  <= 1'b0;
      cnt_op_q   <= OP_NONE;
      cnt_clr_q  <= 1'b0;
      stop_q     <= 1'b1;
      winner_q   <= 2'b00;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_l_q   <= slot_l_d;
      slot_r_q   <= slot_r_d;
      rr_q       <= rr_d;
      cnt_en_q   <= cnt_en_d;
      cnt_sel_q  <= cnt_sel_d;
      cnt_op_q   <= cnt_op_d;
      cnt_clr_q  <= cnt_clr_d;
      stop_q     <= stop_d;
      winner_q   <= winner_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CLEAR;
      S_CLEAR: state_d = S_PLAY;
      // A guarded-away op just empties its slot and leaves us in PLAY.
      S_PLAY:  if (grant_valid && grant_op != OP_NONE) state_d = S_ISSUE;
      S_ISSUE: state_d = S_CHECK;
      S_CHECK: state_d = (scoreL >= WIN_SCORE || scoreR >= WIN_SCORE) ? S_OVER : S_PLAY;
      S_OVER:  if (start) state_d = S_CLEAR;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    slot_l_d   = slot_l_q;
    slot_r_d   = slot_r_q;
    rr_d       = rr_q;
    overflow_d = overflow_q;
    winner_d   = winner_q;
    if (state_q == S_IDLE || state_q == S_OVER || state_d == S_OVER) begin
      slot_l_d = OP_NONE;
      slot_r_d = OP_NONE;
    end else begin
      if (state_q == S_CLEAR || (grant_valid && !grant_sel)) slot_l_d = OP_NONE;
      if (state_q == S_CLEAR || (grant_valid &&  grant_sel)) slot_r_d = OP_NONE;
      // Occupancy is judged on the pre-grant slot, so a request landing on
      // the cycle its slot is granted still counts as an overflow.
      if (req_l != OP_NONE) begin
        if (l_full && state_q != S_CLEAR) overflow_d = 1'b1;
        else                              slot_l_d   = req_l;
      end
      if (req_r != OP_NONE) begin
        if (r_full && state_q != S_CLEAR) overflow_d = 1'b1;
        else                              slot_r_d   = req_r;
      end
    end
    if (grant_valid && l_full && r_full) rr_d = ~rr_q;

    cnt_en_d  = (state_q == S_PLAY) && (state_d == S_ISSUE);
    cnt_op_d  = cnt_en_d ? grant_op : OP_NONE;
    cnt_sel_d = cnt_en_d ? grant_sel : cnt_sel_q;
    cnt_clr_d = (state_d == S_CLEAR);
    stop_d    = !(state_d == S_PLAY || state_d == S_ISSUE || state_d == S_CHECK);
    if (state_d == S_CLEAR) begin
      winner_d   = 2'b00;
      overflow_d = 1'b0;
    end else if (state_q == S_CHECK && state_d == S_OVER) begin
      winner_d = (scoreL >= WIN_SCORE) ? 2'b01 : 2'b10;
    end
  end

  assign cnt_en   = cnt_en_q;
  assign cnt_sel  = cnt_sel_q;
  assign cnt_op   = cnt_op_q;
  assign cnt_clr  = cnt_clr_q;
  assign stop     = stop_q;
  assign winner   = winner_q;
  assign overflow = overflow_q;

endmodule
`default_nettype wire
